// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
//   Shared constants for the register-file writeback arbiter: source IDs
//   carried in the order queue, the hard-wired zero register, and the
//   register-address / data widths of the single write port.
package regfile_wb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    // Source IDs stored in the order queue
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles both writeback request channels, the issue stall, the register
//   file write port and the hazard/idle status.
//
//   Handshake: a request on a channel is taken at a rising edge where
//   x_valid & x_ready are both 1. Ready never depends on valid, and a
//   source may drop or change its request freely while ready is 0.
//
//   Signals
//     a_valid/a_ready/a_rd/a_data  source A (execute result)
//     b_valid/b_ready/b_rd/b_data  source B (load data)
//     stall                        freeze issue
//     LE/RW/PW                     register file write enable/address/data
//     pend_mask                    registers with a buffered, unissued write
//     idle                         nothing buffered and no write in flight
//   Modports: master = the sources and pipeline control, slave = the arbiter.
interface regfile_wb_arbiter_if;
    import regfile_wb_pkg::*;

    logic                a_valid;
    logic                a_ready;
    logic [REG_AW-1:0]   a_rd;
    logic [DATA_W-1:0]   a_data;
    logic                b_valid;
    logic                b_ready;
    logic [REG_AW-1:0]   b_rd;
    logic [DATA_W-1:0]   b_data;
    logic                stall;
    logic                LE;
    logic [REG_AW-1:0]   RW;
    logic [DATA_W-1:0]   PW;
    logic [NUM_REGS-1:0] pend_mask;
    logic                idle;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, stall,
        input  a_ready, b_ready, LE, RW, PW, pend_mask, idle
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, stall,
        output a_ready, b_ready, LE, RW, PW, pend_mask, idle
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo
//   Per-source writeback FIFO holding {rd, data}. Besides the usual head
//   and occupancy it exposes every slot's rd and a valid bit, so the top
//   level can build the pending-write mask over all buffered entries.
//
//   Ports
//     clk, reset            clock, asynchronous active-low reset
//     i_push, i_rd, i_data  write one entry (caller guarantees not full)
//     i_pop                 drop the head entry (caller guarantees not empty)
//     o_count               number of valid entries, 0..DEPTH
//     o_head_rd/o_head_data oldest entry
//     o_ent_valid/o_ent_rd  per-slot valid flag and destination register
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic [REG_AW-1:0]             i_rd,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic [CW-1:0]                 o_count,
    output logic [REG_AW-1:0]             o_head_rd,
    output logic [DATA_W-1:0]             o_head_data,
    output logic [DEPTH-1:0]              o_ent_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  o_ent_rd
);

    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [REG_AW-1:0] r_rd_mem   [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: a slot is only looked at while it is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_rd_mem[r_wptr]   <= i_rd;
            r_data_mem[r_wptr] <= i_data;
        end
    end

    // Slot i is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_valid[i] = ({1'b0, AW'(i) - r_rptr} < r_count);
            o_ent_rd[i]    = r_rd_mem[i];
        end
    end

    assign o_count     = r_count;
    assign o_head_rd   = r_rd_mem[r_rptr];
    assign o_head_data = r_data_mem[r_rptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between source A (execute)
//   and source B (loads). Accepted writes are buffered per source and issued
//   one per cycle in strict arrival order, tracked by an order queue of
//   source IDs, so program order to any register is preserved.
//
//   Ports
//     clk    system clock (rising edge)
//     reset  asynchronous active-low reset
//     bus    regfile_wb_arbiter_if.slave: requests, stall, write port, status
//   Parameters
//     DEPTH   entries per source FIFO (power of two, >= 2)
//     B_FIRST on same-cycle arrival B is ordered ahead of A when 1
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter bit B_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int OAW = $clog2(2 * DEPTH);
    localparam int OCW = OAW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic                         r_run;
    logic                         w_a_ready, w_b_ready;
    logic                         w_push_a, w_push_b;
    logic                         w_pop_a, w_pop_b;
    logic                         w_issue, w_head_src, w_first;
    logic [OCW-1:0]               w_n_push;
    logic [CW-1:0]                w_cnt_a, w_cnt_b;
    logic [REG_AW-1:0]            w_a_head_rd, w_b_head_rd, w_head_rd;
    logic [DATA_W-1:0]            w_a_head_data, w_b_head_data, w_head_data;
    logic [DEPTH-1:0]             w_a_vld, w_b_vld;
    logic [DEPTH-1:0][REG_AW-1:0] w_a_ent_rd, w_b_ent_rd;
    logic [NUM_REGS-1:0]          w_pend;

    logic [2*DEPTH-1:0]           r_ord;
    logic [OAW-1:0]               r_ord_wptr, r_ord_rptr;
    logic [OCW-1:0]               r_ord_cnt;
    logic                         r_le;
    logic [REG_AW-1:0]            r_rw;
    logic [DATA_W-1:0]            r_pw;

    // run holds ready low for the first cycle out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // Ready looks only at stored occupancy, never at a same-cycle pop.
    assign w_a_ready = r_run && (w_cnt_a < FULL_CNT);
    assign w_b_ready = r_run && (w_cnt_b < FULL_CNT);

    // Writes to the zero register are accepted but dropped here.
    assign w_push_a = bus.a_valid && w_a_ready && (bus.a_rd != REG_ZERO);
    assign w_push_b = bus.b_valid && w_b_ready && (bus.b_rd != REG_ZERO);
    assign w_n_push = OCW'(w_push_a) + OCW'(w_push_b);

    assign w_issue    = !bus.stall && (r_ord_cnt != '0);
    assign w_head_src = r_ord[r_ord_rptr];
    assign w_pop_a    = w_issue && (w_head_src == SRC_A);
    assign w_pop_b    = w_issue && (w_head_src == SRC_B);
    assign w_first    = B_FIRST ? SRC_B : SRC_A;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .reset(reset),
        .i_push(w_push_a), .i_rd(bus.a_rd), .i_data(bus.a_data), .i_pop(w_pop_a),
        .o_count(w_cnt_a), .o_head_rd(w_a_head_rd), .o_head_data(w_a_head_data),
        .o_ent_valid(w_a_vld), .o_ent_rd(w_a_ent_rd)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .reset(reset),
        .i_push(w_push_b), .i_rd(bus.b_rd), .i_data(bus.b_data), .i_pop(w_pop_b),
        .o_count(w_cnt_b), .o_head_rd(w_b_head_rd), .o_head_data(w_b_head_data),
        .o_ent_valid(w_b_vld), .o_ent_rd(w_b_ent_rd)
    );

    assign w_head_rd   = (w_head_src == SRC_B) ? w_b_head_rd   : w_a_head_rd;
    assign w_head_data = (w_head_src == SRC_B) ? w_b_head_data : w_a_head_data;

    // Order queue: one source ID per buffered write. Its occupancy always
    // equals count_a + count_b, so it cannot overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ord      <= '0;
            r_ord_wptr <= '0;
            r_ord_rptr <= '0;
            r_ord_cnt  <= '0;
        end else begin
            if (w_push_a && w_push_b) begin
                r_ord[r_ord_wptr]           <= w_first;
                r_ord[r_ord_wptr + OAW'(1)] <= ~w_first;
                r_ord_wptr                  <= r_ord_wptr + OAW'(2);
            end else if (w_push_a) begin
                r_ord[r_ord_wptr] <= SRC_A;
                r_ord_wptr        <= r_ord_wptr + OAW'(1);
            end else if (w_push_b) begin
                r_ord[r_ord_wptr] <= SRC_B;
                r_ord_wptr        <= r_ord_wptr + OAW'(1);
            end
            if (w_issue) r_ord_rptr <= r_ord_rptr + OAW'(1);
            r_ord_cnt <= r_ord_cnt + w_n_push - OCW'(w_issue);
        end
    end

    // Write-port registers; RW/PW keep their last value when nothing issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_le <= 1'b0;
            r_rw <= '0;
            r_pw <= '0;
        end else begin
            r_le <= w_issue;
            if (w_issue) begin
                r_rw <= w_head_rd;
                r_pw <= w_head_data;
            end
        end
    end

    // The entry in the write-port registers has already left its FIFO, so
    // it drops out of the mask; the register file forwards it while LE = 1.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_a_vld[i]) w_pend[w_a_ent_rd[i]] = 1'b1;
            if (w_b_vld[i]) w_pend[w_b_ent_rd[i]] = 1'b1;
        end
    end

    assign bus.a_ready   = w_a_ready;
    assign bus.b_ready   = w_b_ready;
    assign bus.LE        = r_le;
    assign bus.RW        = r_rw;
    assign bus.PW        = r_pw;
    assign bus.pend_mask = w_pend;
    assign bus.idle      = (w_cnt_a == '0) && (w_cnt_b == '0) && !r_le;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH = 2, B_FIRST = 1).
// Inputs change on the falling edge and outputs are sampled there too,
// half a cycle away from the rising edge where the DUT acts.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] rf [32];

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(2), .B_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Register file model, written through the DUT's write port.
    always @(posedge clk) begin
        if (bus.LE === 1'b1) rf[bus.RW] <= bus.PW;
    end

    task automatic drive_idle();
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
        bus.stall   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL reset_le got=%0h exp=0", bus.LE); end
        n_cmp++; if (bus.RW !== 5'd0) begin n_bad++; $display("FAIL reset_rw got=%0h exp=0", bus.RW); end
        n_cmp++; if (bus.PW !== 32'd0) begin n_bad++; $display("FAIL reset_pw got=%0h exp=0", bus.PW); end
        n_cmp++; if (bus.pend_mask !== 32'd0) begin n_bad++; $display("FAIL reset_pend got=%0h exp=0", bus.pend_mask); end
        n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got=%0h exp=1", bus.idle); end
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL reset_a_ready got=%0h exp=0", bus.a_ready); end
        n_cmp++; if (bus.b_ready !== 1'b0) begin n_bad++; $display("FAIL reset_b_ready got=%0h exp=0", bus.b_ready); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL release_a_ready_early got=%0h exp=0", bus.a_ready); end
        @(negedge clk);
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL release_a_ready got=%0h exp=1", bus.a_ready); end
        n_cmp++; if (bus.b_ready !== 1'b1) begin n_bad++; $display("FAIL release_b_ready got=%0h exp=1", bus.b_ready); end
    endtask

    task automatic test_single_write();
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
        @(negedge clk);
        bus.a_valid = 1'b0;
        n_cmp++; if (bus.pend_mask !== 32'h20) begin n_bad++; $display("FAIL single_pend got=%0h exp=20", bus.pend_mask); end
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL single_le_early got=%0h exp=0", bus.LE); end
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b1) begin n_bad++; $display("FAIL single_le got=%0h exp=1", bus.LE); end
        n_cmp++; if (bus.RW !== 5'd5) begin n_bad++; $display("FAIL single_rw got=%0h exp=5", bus.RW); end
        n_cmp++; if (bus.PW !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_pw got=%0h exp=deadbeef", bus.PW); end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL single_pend_clear got=%0h exp=0", bus.pend_mask); end
        n_cmp++; if (bus.idle !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got=%0h exp=0", bus.idle); end
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL single_le_after got=%0h exp=0", bus.LE); end
        n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL single_idle got=%0h exp=1", bus.idle); end
        n_cmp++; if (rf[5] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_rf5 got=%0h exp=deadbeef", rf[5]); end
    endtask

    task automatic test_same_cycle();
        bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h11;
        bus.b_valid = 1'b1; bus.b_rd = 5'd3; bus.b_data = 32'h22;
        @(negedge clk);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        n_cmp++; if (bus.pend_mask !== 32'h8) begin n_bad++; $display("FAIL same_pend got=%0h exp=8", bus.pend_mask); end
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b1) begin n_bad++; $display("FAIL same_le1 got=%0h exp=1", bus.LE); end
        n_cmp++; if (bus.PW !== 32'h22) begin n_bad++; $display("FAIL same_first_pw got=%0h exp=22", bus.PW); end
        n_cmp++; if (bus.pend_mask !== 32'h8) begin n_bad++; $display("FAIL same_pend_mid got=%0h exp=8", bus.pend_mask); end
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b1) begin n_bad++; $display("FAIL same_le2 got=%0h exp=1", bus.LE); end
        n_cmp++; if (bus.RW !== 5'd3) begin n_bad++; $display("FAIL same_rw2 got=%0h exp=3", bus.RW); end
        n_cmp++; if (bus.PW !== 32'h11) begin n_bad++; $display("FAIL same_second_pw got=%0h exp=11", bus.PW); end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL same_pend_end got=%0h exp=0", bus.pend_mask); end
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL same_le_after got=%0h exp=0", bus.LE); end
        n_cmp++; if (rf[3] !== 32'h11) begin n_bad++; $display("FAIL same_rf3 got=%0h exp=11", rf[3]); end
    endtask

    task automatic test_rd_zero();
        bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL zero_accept got=%0h exp=1", bus.a_ready); end
        @(negedge clk);
        bus.a_valid = 1'b0;
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL zero_pend got=%0h exp=0", bus.pend_mask); end
        n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL zero_idle got=%0h exp=1", bus.idle); end
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL zero_le got=%0h exp=0", bus.LE); end
        n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL zero_idle2 got=%0h exp=1", bus.idle); end
    endtask

    task automatic test_backpressure();
        bus.stall = 1'b1;
        bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'h101;
        @(negedge clk);
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one got=%0h exp=1", bus.a_ready); end
        bus.a_rd = 5'd2; bus.a_data = 32'h102;
        @(negedge clk);
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full got=%0h exp=0", bus.a_ready); end
        n_cmp++; if (bus.pend_mask !== 32'h6) begin n_bad++; $display("FAIL bp_pend got=%0h exp=6", bus.pend_mask); end
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL bp_le_stall got=%0h exp=0", bus.LE); end
        bus.a_rd = 5'd3; bus.a_data = 32'h103;
        @(negedge clk);
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_hold got=%0h exp=0", bus.a_ready); end
        n_cmp++; if (bus.pend_mask !== 32'h6) begin n_bad++; $display("FAIL bp_pend_hold got=%0h exp=6", bus.pend_mask); end
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL bp_le_hold got=%0h exp=0", bus.LE); end
        bus.stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b1) begin n_bad++; $display("FAIL bp_le1 got=%0h exp=1", bus.LE); end
        n_cmp++; if (bus.RW !== 5'd1) begin n_bad++; $display("FAIL bp_rw1 got=%0h exp=1", bus.RW); end
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_again got=%0h exp=1", bus.a_ready); end
        n_cmp++; if (bus.pend_mask !== 32'h4) begin n_bad++; $display("FAIL bp_pend_after1 got=%0h exp=4", bus.pend_mask); end
        @(negedge clk);
        bus.a_valid = 1'b0;
        n_cmp++; if (bus.RW !== 5'd2) begin n_bad++; $display("FAIL bp_rw2 got=%0h exp=2", bus.RW); end
        n_cmp++; if (bus.PW !== 32'h102) begin n_bad++; $display("FAIL bp_pw2 got=%0h exp=102", bus.PW); end
        n_cmp++; if (bus.pend_mask !== 32'h8) begin n_bad++; $display("FAIL bp_pend_rd3 got=%0h exp=8", bus.pend_mask); end
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b1) begin n_bad++; $display("FAIL bp_le3 got=%0h exp=1", bus.LE); end
        n_cmp++; if (bus.RW !== 5'd3) begin n_bad++; $display("FAIL bp_rw3 got=%0h exp=3", bus.RW); end
        n_cmp++; if (bus.PW !== 32'h103) begin n_bad++; $display("FAIL bp_pw3 got=%0h exp=103", bus.PW); end
        @(negedge clk);
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL bp_le_end got=%0h exp=0", bus.LE); end
        n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL bp_idle got=%0h exp=1", bus.idle); end
        n_cmp++; if (rf[2] !== 32'h102) begin n_bad++; $display("FAIL bp_rf2 got=%0h exp=102", rf[2]); end
    endtask

    task automatic test_interleaved();
        bus.stall = 1'b1;
        bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'h7;
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_rd = 5'd8; bus.b_data = 32'h8;
        n_cmp++; if (bus.b_ready !== 1'b1) begin n_bad++; $display("FAIL il_b_ready got=%0h exp=1", bus.b_ready); end
        @(negedge clk);
        bus.b_valid = 1'b0;
        bus.a_valid = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'h9;
        @(negedge clk);
        bus.a_valid = 1'b0;
        n_cmp++; if (bus.pend_mask !== 32'h380) begin n_bad++; $display("FAIL il_pend got=%0h exp=380", bus.pend_mask); end
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL il_le_stall got=%0h exp=0", bus.LE); end
        bus.stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.RW !== 5'd7 || bus.LE !== 1'b1) begin n_bad++; $display("FAIL il_first got rw=%0h le=%0h exp rw=7 le=1", bus.RW, bus.LE); end
        @(negedge clk);
        n_cmp++; if (bus.RW !== 5'd8 || bus.PW !== 32'h8) begin n_bad++; $display("FAIL il_second got rw=%0h pw=%0h exp rw=8 pw=8", bus.RW, bus.PW); end
        @(negedge clk);
        n_cmp++; if (bus.RW !== 5'd9 || bus.LE !== 1'b1) begin n_bad++; $display("FAIL il_third got rw=%0h le=%0h exp rw=9 le=1", bus.RW, bus.LE); end
        @(negedge clk);
        n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL il_idle got=%0h exp=1", bus.idle); end
    endtask

    task automatic test_mid_reset();
        bus.stall = 1'b1;
        bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'hA0;
        @(negedge clk);
        bus.a_rd = 5'd11; bus.a_data = 32'hB0;
        @(negedge clk);
        bus.a_valid = 1'b0;
        n_cmp++; if (bus.pend_mask !== 32'hC00) begin n_bad++; $display("FAIL mr_pend_before got=%0h exp=c00", bus.pend_mask); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL mr_le got=%0h exp=0", bus.LE); end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL mr_pend got=%0h exp=0", bus.pend_mask); end
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL mr_a_ready got=%0h exp=0", bus.a_ready); end
        n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL mr_idle got=%0h exp=1", bus.idle); end
        @(negedge clk);
        reset = 1'b1;
        bus.stall = 1'b0;
        #1;
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL mr_ready_early got=%0h exp=0", bus.a_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.LE !== 1'b0) begin n_bad++; $display("FAIL mr_stale_le cycle=%0d got=%0h exp=0", i, bus.LE); end
            if (i == 0) begin
                n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL mr_ready got=%0h exp=1", bus.a_ready); end
            end
        end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL mr_pend_after got=%0h exp=0", bus.pend_mask); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        drive_idle();
        reset = 1'b0;
        test_reset();
        test_single_write();
        test_same_cycle();
        test_rd_zero();
        test_backpressure();
        test_interleaved();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port (LE/RW/PW) between two writeback sources: A (ALU/execute result) and B (load data from memory). Each source has a small FIFO with a valid/ready handshake. Writes issue one per cycle, in strict arrival order, so program order to any register is preserved. The block also exports a pending-write mask that the hazard unit uses to stall decode.

## Interface
- DEPTH, 2, entries per source FIFO (power of two, ≥2)
- B_FIRST, 1, on same-cycle arrival of A and B, B is ordered first (0 = A first)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- a_valid  in  1  source A write request
- a_ready  out  1  source A may present a request
- a_rd  in  5  source A destination register
- a_data  in  32  source A write data
- b_valid, b_ready, b_rd, b_data  same as A, for source B
- stall  in  1  hold issue (pipeline freeze)
- LE  out  1  register file write enable
- RW  out  5  register file write address
- PW  out  32  register file write data
- pend_mask  out  32  bit i = 1 when a buffered (not yet issued) write targets register i
- idle  out  1  both FIFOs empty and LE = 0

## Operation
- **Accept.** A request is accepted at an edge where valid & ready.
  - rd = 0 requests are accepted and discarded. They enter no FIFO, never produce LE, and leave pend_mask unchanged.
- **Buffering.** Accepted nonzero requests are pushed into their source FIFO. The source ID is pushed into an order queue of 2·DEPTH entries.
  - Same-cycle A+B arrival pushes two IDs; the order is set by B_FIRST.
- **Ready.** a_ready = (count_a < DEPTH) & run.
  - run is a flop cleared by reset and set at the first edge after reset is released.
  - Ready does not depend on a same-cycle pop.
- **Issue.** At each edge where stall = 0 and the order queue is non-empty:
  - pop the head ID and the head of that source's FIFO;
  - load LE = 1, RW = rd, PW = data into the output registers.
  - Otherwise LE loads 0, and RW/PW hold their values.
- **pend_mask.** OR-decode of rd over all valid entries of both FIFOs.
  - The entry held in the output registers is excluded, because the register file forwards PW on read when LE = 1.
- **Back-to-back.** Two back-to-back writes to the same register both issue, in order. The later one wins in the register file.

## Timing
- Reset (reset = 0, asynchronous):
  - FIFOs and order queue empty;
  - LE = 0, RW = 0, PW = 0, pend_mask = 0, idle = 1;
  - a_ready = b_ready = 0.
- Ready rises one cycle after reset is released.
- Latency, accept at edge k with empty queues and stall = 0:
  - pend_mask bit set during cycle k→k+1;
  - LE/RW/PW valid during cycle k+1→k+2;
  - register file commits at edge k+2.
- Throughput: one write per cycle. Sustained A+B arrival fills the FIFOs; ready then drops on the first full source.
- Boundaries:
  - **Push to a full FIFO.** Impossible by the handshake; the assertion is a bench check.
  - **Push and pop in the same cycle.** Both take effect. The count is unchanged.
  - **stall = 1.** LE = 0 the next cycle. FIFO contents and pend_mask are held; accepts continue until full.
  - **Reset mid-operation.** All buffered writes are lost. No LE pulse occurs after reset asserts.
- Pointers wrap modulo DEPTH (FIFOs) and modulo 2·DEPTH (order queue).

## Structure
- Package regfile_wb_pkg holds:
  - SRC_A = 1'b0, SRC_B = 1'b1;
  - REG_ZERO = 5'd0;
  - REG_AW = 5, DATA_W = 32.
- Sub-module wb_fifo (one per source, parameter DEPTH) stores {rd, data}. It outputs count, head, and a per-entry valid/rd vector used for pend_mask.
- The order queue, issue logic and output registers live in the top level.

## Test plan
- **Reset mid-stream.** Buffer 2 A writes, then pull reset = 0 → LE = 0, pend_mask = 0, ready = 0 immediately. After release, ready = 1 one cycle later and no stale LE appears.
- **Single write.** A(rd = 5, 0xDEADBEEF) accepted at edge k, stall = 0 → pend_mask = 0x20 in cycle k→k+1. LE = 1, RW = 5, PW = 0xDEADBEEF in cycle k+1→k+2. idle = 1 after that.
- **Same-cycle arrival.** A(rd = 3, 0x11) and B(rd = 3, 0x22) arrive together, B_FIRST = 1 → B issues first, then A on the next cycle. The register file ends with r3 = 0x11.
- **rd = 0.** A(rd = 0, 0xFFFFFFFF) → accepted, LE stays 0, pend_mask stays 0.
- **Backpressure.** stall = 1; push A with rd = 1, 2, 3 on consecutive cycles (DEPTH = 2) → a_ready = 0 after the second accept and pend_mask = 0x6. Drop stall → RW = 1 then RW = 2 on consecutive cycles; the rd = 3 request is then accepted and issues next.
- **Interleaved order.** With stall = 1, push A(rd = 7) at k, B(rd = 8) at k+1, A(rd = 9) at k+2. Release stall → issue order is RW = 7, 8, 9.
